// File: rtl/ll_hl_pkg.sv
// Shared types and constants for the low-level arithmetic blocks.
// Holds the serial subtractor state encoding and default operand width.
package ll_hl_pkg;

   localparam int unsigned DEF_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } sub_state_t;

endpackage

// File: rtl/serial_subtractor_if.sv
// Operand/result handshake bundle for the bit-serial subtractor.
// master drives operands and consumes results; slave is the subtractor.
interface serial_subtractor_if
   import ll_hl_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH
);

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] diff;
   logic             borrow;

   modport master (
      output in_valid,
      output a,
      output b,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  diff,
      input  borrow
   );

   modport slave (
      input  in_valid,
      input  a,
      input  b,
      input  out_ready,
      output in_ready,
      output out_valid,
      output diff,
      output borrow
   );

endinterface

// File: rtl/half_subtractor.sv
// Combinational half subtractor: d = x - y (one bit), bo = borrow out.
module half_subtractor (
   input  logic x,
   input  logic y,
   output logic d,
   output logic bo
);

   assign d  = x ^ y;
   assign bo = ~x & y;

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor (diff = a - b), one bit per clock, LSB first,
// with valid/ready handshakes on operands and result.
module serial_subtractor
   import ll_hl_pkg::*;
#(
   parameter int unsigned WIDTH = DEF_WIDTH
) (
   input  logic                clk,
   input  logic                rstn,
   serial_subtractor_if.slave  bus
);

   localparam int unsigned      CNT_W    = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

   sub_state_t       state;
   sub_state_t       state_n;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_n;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] a_sr_n;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] b_sr_n;
   logic [WIDTH-2:0] dsr;
   logic [WIDTH-2:0] dsr_n;
   logic             bin;
   logic             bin_n;
   logic [WIDTH-1:0] diff_q;
   logic [WIDTH-1:0] diff_n;
   logic             borrow_q;
   logic             borrow_n;
   logic             in_ready_q;
   logic             in_ready_n;
   logic             out_valid_q;
   logic             out_valid_n;

   logic             d1_c;
   logic             bo1_c;
   logic             d_c;
   logic             bo2_c;
   logic             bout_c;

   // Full subtractor on the current LSBs built from two half subtractors.
   half_subtractor u_hs_ab (
      .x  (a_sr[0]),
      .y  (b_sr[0]),
      .d  (d1_c),
      .bo (bo1_c)
   );

   half_subtractor u_hs_bin (
      .x  (d1_c),
      .y  (bin),
      .d  (d_c),
      .bo (bo2_c)
   );

   assign bout_c = bo1_c | bo2_c;

   // Next-state and next-register logic; everything holds unless stated.
   always_comb begin
      state_n     = state;
      cnt_n       = cnt;
      a_sr_n      = a_sr;
      b_sr_n      = b_sr;
      dsr_n       = dsr;
      bin_n       = bin;
      diff_n      = diff_q;
      borrow_n    = borrow_q;

      case (state)
         IDLE: begin
            if (bus.in_valid && in_ready_q) begin
               a_sr_n  = bus.a;
               b_sr_n  = bus.b;
               dsr_n   = '0;
               bin_n   = 1'b0;
               cnt_n   = '0;
               state_n = CALC;
            end
         end
         CALC: begin
            a_sr_n = a_sr >> 1;
            b_sr_n = b_sr >> 1;
            bin_n  = bout_c;
            dsr_n  = (WIDTH-1)'({d_c, dsr} >> 1);
            cnt_n  = cnt + CNT_W'(1);
            // Published result is loaded only on the final bit so it stays
            // frozen at its previous value while the next one is computed.
            if (cnt == LAST_CNT) begin
               diff_n   = {d_c, dsr};
               borrow_n = bout_c;
               state_n  = DONE;
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               state_n = IDLE;
            end
         end
         default: begin
            state_n = IDLE;
         end
      endcase

      in_ready_n  = (state_n == IDLE);
      out_valid_n = (state_n == DONE);
   end

   // State and datapath registers.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state       <= IDLE;
         cnt         <= '0;
         a_sr        <= '0;
         b_sr        <= '0;
         dsr         <= '0;
         bin         <= 1'b0;
         diff_q      <= '0;
         borrow_q    <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
      end else begin
         state       <= state_n;
         cnt         <= cnt_n;
         a_sr        <= a_sr_n;
         b_sr        <= b_sr_n;
         dsr         <= dsr_n;
         bin         <= bin_n;
         diff_q      <= diff_n;
         borrow_q    <= borrow_n;
         in_ready_q  <= in_ready_n;
         out_valid_q <= out_valid_n;
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.diff      = diff_q;
   assign bus.borrow    = borrow_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: directed operands with hand-computed
// results, checked by an independent output monitor.
module tb_serial_subtractor;
   import ll_hl_pkg::*;

   localparam int unsigned WIDTH = 8;

   typedef struct {
      logic [WIDTH-1:0] diff;
      logic             borrow;
      int               acc_cyc;
      string            name;
   } exp_t;

   logic clk = 1'b0;
   logic rstn;
   int   checks = 0;
   int   fails  = 0;
   int   cyc    = 0;
   exp_t sb[$];
   exp_t got_e;
   logic prev_ov = 1'b0;

   serial_subtractor_if #(.WIDTH(WIDTH)) bus ();

   serial_subtractor #(.WIDTH(WIDTH)) dut (
      .clk  (clk),
      .rstn (rstn),
      .bus  (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   task automatic flag(input string name);
      checks++;
      fails++;
      $display("FAIL %s (t=%0t)", name, $time);
   endtask

   // Output monitor: latency on rising out_valid, result on handshake.
   always @(negedge clk) begin
      if (!rstn) begin
         prev_ov = 1'b0;
      end else begin
         check("ready_valid_exclusive", 32'(bus.in_ready & bus.out_valid), 32'd0);
         if (bus.out_valid && !prev_ov) begin
            if (sb.size() == 0) flag("unexpected_output");
            else check({sb[0].name, "_latency"}, 32'(cyc - sb[0].acc_cyc), 32'(WIDTH));
         end
         if (bus.out_valid && bus.out_ready && sb.size() > 0) begin
            got_e = sb.pop_front();
            check({got_e.name, "_diff"}, 32'(bus.diff), 32'(got_e.diff));
            check({got_e.name, "_borrow"}, 32'(bus.borrow), 32'(got_e.borrow));
         end
         prev_ov = bus.out_valid;
      end
   end

   task automatic issue(input string name, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [WIDTH-1:0] ed, input logic eb);
      int n = 0;
      while (!bus.in_ready && n < 50) begin
         @(posedge clk); #1;
         n++;
      end
      if (!bus.in_ready) flag({name, "_in_ready_timeout"});
      bus.in_valid = 1'b1;
      bus.a        = a;
      bus.b        = b;
      @(posedge clk); #1;
      sb.push_back('{ed, eb, cyc, name});
      bus.in_valid = 1'b0;
   endtask

   task automatic drain(input string name);
      int n = 0;
      while (sb.size() != 0 && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (sb.size() != 0) begin
         flag({name, "_result_timeout"});
         sb.delete();
      end
      @(posedge clk); #1;
      check({name, "_post_in_ready"}, 32'(bus.in_ready), 32'd1);
      check({name, "_post_out_valid"}, 32'(bus.out_valid), 32'd0);
   endtask

   initial begin
      int n;
      bus.in_valid  = 1'b0;
      bus.a         = '0;
      bus.b         = '0;
      bus.out_ready = 1'b1;
      rstn          = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_in_ready", 32'(bus.in_ready), 32'd1);
      check("rst_out_valid", 32'(bus.out_valid), 32'd0);
      check("rst_diff", 32'(bus.diff), 32'd0);
      check("rst_borrow", 32'(bus.borrow), 32'd0);
      rstn = 1'b1;
      @(posedge clk); #1;
      check("release_in_ready", 32'(bus.in_ready), 32'd1);

      issue("basic", 8'd200, 8'd55, 8'd145, 1'b0);
      drain("basic");
      issue("borrow", 8'd5, 8'd7, 8'd254, 1'b1);
      drain("borrow");
      issue("equal", 8'hA5, 8'hA5, 8'h00, 1'b0);
      drain("equal");

      // Backpressure: result must hold for 5 cycles with out_ready low.
      bus.out_ready = 1'b0;
      issue("bp", 8'd9, 8'd3, 8'd6, 1'b0);
      n = 0;
      while (!bus.out_valid && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!bus.out_valid) flag("bp_valid_timeout");
      for (int i = 0; i < 5; i++) begin
         check("bp_hold_valid", 32'(bus.out_valid), 32'd1);
         check("bp_hold_diff", 32'(bus.diff), 32'd6);
         check("bp_hold_borrow", 32'(bus.borrow), 32'd0);
         check("bp_hold_in_ready", 32'(bus.in_ready), 32'd0);
         if (i < 4) @(negedge clk);
      end
      @(posedge clk); #1;
      bus.out_ready = 1'b1;
      drain("bp");

      // Second request while busy must be ignored.
      issue("busy", 8'd100, 8'd1, 8'd99, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      bus.in_valid = 1'b1;
      bus.a        = 8'd1;
      bus.b        = 8'd1;
      @(posedge clk); #1;
      bus.in_valid = 1'b0;
      drain("busy");
      repeat (WIDTH + 3) @(posedge clk);
      #1;
      check("busy_no_second_in_ready", 32'(bus.in_ready), 32'd1);
      check("busy_no_second_out_valid", 32'(bus.out_valid), 32'd0);

      // Reset in the middle of a calculation discards it.
      issue("aborted", 8'd50, 8'd20, 8'd30, 1'b0);
      repeat (3) @(posedge clk);
      #1;
      rstn = 1'b0;
      sb.delete();
      @(posedge clk); #1;
      rstn = 1'b1;
      check("midrst_in_ready", 32'(bus.in_ready), 32'd1);
      check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
      check("midrst_diff", 32'(bus.diff), 32'd0);
      @(posedge clk); #1;
      check("midrst_in_ready_2", 32'(bus.in_ready), 32'd1);
      issue("after_rst", 8'd3, 8'd2, 8'd1, 1'b0);
      drain("after_rst");

      repeat (2) @(posedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog_timeout");
      $fatal(1, "watchdog");
   end

endmodule
